// File: rtl/sumator_multicuvant_pkg.sv
// Shared definitions for the multi-precision adder sequencer: FSM encoding and
// the index-width helper.
package sumator_multicuvant_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Word-index width; kept at one bit even when only a single word exists.
    function automatic int unsigned idx_width(input int unsigned words);
        int unsigned w;
        w = (words > 1) ? $clog2(words) : 1;
        return w;
    endfunction

endpackage

// File: rtl/sumator_cin.sv
// N-bit combinational word adder with carry-in; the only arithmetic path of the
// sequencer.
module sumator_cin #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] sum_full;

    assign sum_full  = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    assign {cout, s} = sum_full;

endmodule

// File: rtl/sumator_multicuvant.sv
// Multi-precision adder sequencer: feeds one N-bit word per cycle, LSW first,
// into sumator_cin. Define SIGNED_OVF_EN to add the signed-overflow output ovf.
module sumator_multicuvant
    import sumator_multicuvant_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] result,
    output logic           cout
`ifdef SIGNED_OVF_EN
    ,
    output logic           ovf
`endif
);

    localparam int unsigned TOT_W = N * W;
    localparam int unsigned IDX_W = idx_width(W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

    state_e             state_q, state_d;
    logic [TOT_W-1:0]   a_q, a_d;
    logic [TOT_W-1:0]   b_q, b_d;
    logic [TOT_W-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
`ifdef SIGNED_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [N-1:0]       a_word;
    logic [N-1:0]       b_word;
    logic [N-1:0]       sum_s;
    logic               sum_c;

    // Word mux selecting the current operand slice by idx.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_word = a_q[i*N +: N];
                b_word = b_q[i*N +: N];
            end
        end
    end

    sumator_cin #(
        .N (N)
    ) u_word_add (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .s    (sum_s),
        .cout (sum_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (idx_q == IDX_LAST) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Last ADD cycle loads cout/done so they are valid together with the FIN cycle.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
`ifdef SIGNED_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ADD: begin
                for (int unsigned i = 0; i < W; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[i*N +: N] = sum_s;
                    end
                end
                carry_d = sum_c;
                if (idx_q == IDX_LAST) begin
                    done_d = 1'b1;
                    cout_d = sum_c;
`ifdef SIGNED_OVF_EN
                    ovf_d  = (a_q[TOT_W-1] == b_q[TOT_W-1]) &&
                             (sum_s[N-1] != a_q[TOT_W-1]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FIN: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
`ifdef SIGNED_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SIGNED_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_sumator_multicuvant.sv
// Directed bench for sumator_multicuvant (N=4/W=2 and N=8/W=1 instances);
// covers ovf when SIGNED_OVF_EN is defined.
module tb_sumator_multicuvant;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] result8;
    logic       cout8;

`ifdef SIGNED_OVF_EN
    logic       ovf;
    logic       ovf8;
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sumator_multicuvant #(.N(4), .W(2)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    sumator_multicuvant #(.N(8), .W(1)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .cout   (cout8)
`ifdef SIGNED_OVF_EN
        ,
        .ovf    (ovf8)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation on the N=4/W=2 instance: latency, result, hold after done.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] er, input logic ec);
        int cyc;
        a = av; b = bv; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_add"}, 32'(busy), 32'd1);
        chk({tag, "_done_add"}, 32'(done), 32'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd2);
        chk({tag, "_result"},  32'(result), 32'(er));
        chk({tag, "_cout"},    32'(cout), 32'(ec));
        chk({tag, "_busy_fin"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"},  32'(busy), 32'd0);
        chk({tag, "_result_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int  cyc;
        logic seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        step();
        step();
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout",   32'(cout),   32'd0);
        chk("rst_done8",  32'(done8),  32'd0);
`ifdef SIGNED_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Test 1: carries out of both words
        run_op("t1", 8'hCE, 8'hAE, 8'h7C, 1'b1);
`ifdef SIGNED_OVF_EN
        chk("t1_ovf", 32'(ovf), 32'd1);
`endif

        // Test 2: inter-word carry, then all-ones
        run_op("t2a", 8'h0F, 8'h01, 8'h10, 1'b0);
`ifdef SIGNED_OVF_EN
        chk("t2a_ovf", 32'(ovf), 32'd0);
`endif
        run_op("t2b", 8'hFF, 8'hFF, 8'hFE, 1'b1);
`ifdef SIGNED_OVF_EN
        chk("t2b_ovf", 32'(ovf), 32'd0);
`endif

        // Test 3: zeros; previous result/cout still visible in first ADD cycle
        a = 8'h00; b = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_result_prev", 32'(result), 32'h0FE);
        chk("t3_cout_prev",   32'(cout),   32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        chk("t3_latency", 32'(cyc),    32'd2);
        chk("t3_result",  32'(result), 32'h000);
        chk("t3_cout",    32'(cout),   32'd0);
        step();

        // Test 4: start held and operands changed while busy; start during FIN
        a = 8'h12; b = 8'h34; start = 1'b1;
        step();
        a = 8'hFF; b = 8'hFF;
        chk("t4_busy", 32'(busy), 32'd1);
        step();
        chk("t4_done_early", 32'(done), 32'd0);
        step();
        chk("t4_done",   32'(done),   32'd1);
        chk("t4_result", 32'(result), 32'h046);
        chk("t4_cout",   32'(cout),   32'd0);
        a = 8'h01; b = 8'h01;
        step();
        start = 1'b0;
        chk("t4_fin_start_ignored", 32'(busy), 32'd0);
        chk("t4_single_done",       32'(done), 32'd0);
        step();
        chk("t4_still_idle", 32'(busy),   32'd0);
        chk("t4_hold",       32'(result), 32'h046);
`ifdef SIGNED_OVF_EN
        chk("t4_ovf", 32'(ovf), 32'd0);
`endif

        // Test 5: reset in the middle of ADD discards the operation
        a = 8'h55; b = 8'h66; start = 1'b1;
        step();
        start = 1'b0;
        rst = 1'b1;
        step();
        chk("t5_busy",   32'(busy),   32'd0);
        chk("t5_done",   32'(done),   32'd0);
        chk("t5_result", 32'(result), 32'd0);
        chk("t5_cout",   32'(cout),   32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | done | busy;
        end
        chk("t5_no_done", 32'(seen), 32'd0);
        run_op("t5b", 8'h3C, 8'h4B, 8'h87, 1'b0);
`ifdef SIGNED_OVF_EN
        chk("t5b_ovf", 32'(ovf), 32'd1);
`endif

        // Test 6: signed-overflow corner operands
        run_op("t6a", 8'h7F, 8'h01, 8'h80, 1'b0);
`ifdef SIGNED_OVF_EN
        chk("t6a_ovf", 32'(ovf), 32'd1);
`endif
        run_op("t6b", 8'h80, 8'h80, 8'h00, 1'b1);
`ifdef SIGNED_OVF_EN
        chk("t6b_ovf", 32'(ovf), 32'd1);
`endif

        // Test 6 (W=1): single ADD cycle then FIN
        a8 = 8'hCE; b8 = 8'hAE; start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("w1_busy", 32'(busy8), 32'd1);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        chk("w1_latency", 32'(cyc),     32'd1);
        chk("w1_result",  32'(result8), 32'h07C);
        chk("w1_cout",    32'(cout8),   32'd1);
`ifdef SIGNED_OVF_EN
        chk("w1_ovf", 32'(ovf8), 32'd1);
`endif
        step();
        chk("w1_done_pulse", 32'(done8), 32'd0);
        chk("w1_busy_idle",  32'(busy8), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
